// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with a one-word holding register
module uart_tx_cfg #(
    parameter int MAX_DATA_BITS = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int LEN_W         = $clog2(MAX_DATA_BITS + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     s_tick,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    input  logic [LEN_W-1:0]         cfg_data_bits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    output logic                     tx,
    output logic                     tx_busy,
    output logic                     tx_done_tick
);
    // The tick counter must reach 2*OVERSAMPLE-1 for a double stop bit.
    localparam int                TICK_W     = $clog2(2 * OVERSAMPLE);
    localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP2_LAST = TICK_W'(2 * OVERSAMPLE - 1);
    localparam logic [LEN_W-1:0]  LEN_MIN    = LEN_W'(5);
    localparam logic [LEN_W-1:0]  LEN_MAX    = LEN_W'(MAX_DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                   state_q, state_d;
    logic [TICK_W-1:0]        tick_q, tick_d;
    logic [LEN_W-1:0]         bit_q, bit_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic [MAX_DATA_BITS-1:0] hold_q, hold_d;
    logic                     hold_full_q, hold_full_d;
    logic                     par_en_q, par_en_d;
    logic                     par_bit_q, par_bit_d;
    logic                     stop2_q, stop2_d;
    logic                     tx_q, tx_d;

    logic [LEN_W-1:0]         len_clamped;
    logic                     load_parity;
    logic                     load;
    logic                     period_end;
    logic [TICK_W-1:0]        period_last;

    assign tx       = tx_q;
    assign tx_ready = ~hold_full_q;
    assign tx_busy  = (state_q != S_IDLE);

    // Frame setup values derived from the live config and the held word, used only on load.
    always_comb begin
        len_clamped = cfg_data_bits;
        if (cfg_data_bits < LEN_MIN) begin
            len_clamped = LEN_MIN;
        end else if (cfg_data_bits > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
        load_parity = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < int'(len_clamped)) begin
                load_parity = load_parity ^ hold_q[i];
            end
        end
    end

    always_comb begin
        period_last = BIT_LAST;
        if (state_q == S_STOP && stop2_q) begin
            period_last = STOP2_LAST;
        end
        period_end = s_tick && (tick_q == period_last);
    end

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        len_d        = len_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        stop2_d      = stop2_q;
        tx_d         = tx_q;
        load         = 1'b0;
        tx_done_tick = 1'b0;

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (state_q != S_IDLE && s_tick) begin
            tick_d = period_end ? '0 : tick_q + TICK_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                load = hold_full_q;
            end
            S_START: begin
                if (period_end) begin
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (period_end) begin
                    if (bit_q == len_q - LEN_W'(1)) begin
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + LEN_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (period_end) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (period_end) begin
                    tx_done_tick = 1'b1;
                    load         = hold_full_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // Loading from IDLE and from the last stop tick are identical, so frames chain gap-free.
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tick_d      = '0;
            bit_d       = '0;
            len_d       = len_clamped;
            par_en_d    = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_bit_d   = load_parity ^ (cfg_parity == 2'b10);
            stop2_d     = cfg_stop2;
            tx_d        = 1'b0;
            state_d     = S_START;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            len_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            len_q       <= len_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            stop2_q     <= stop2_d;
            tx_q        <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_tick;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic [3:0] cfg_data_bits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tick;

    uart_tx_cfg #(.MAX_DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .cfg_data_bits(cfg_data_bits),
        .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .tx(tx), .tx_busy(tx_busy),
        .tx_done_tick(tx_done_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int tick_mode = 0;
    initial begin
        int tcnt = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            case (tick_mode)
                0:       s_tick = 1'b1;
                1:       s_tick = (tcnt % 4 == 0);
                default: s_tick = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Reference model: words accepted, config seen at each edge, expected line per frame.
    logic [7:0] pending[$];
    logic [3:0] e_bits;
    logic [1:0] e_par;
    logic       e_s2;

    always @(posedge clk) begin
        e_bits = cfg_data_bits;
        e_par  = cfg_parity;
        e_s2   = cfg_stop2;
        if (reset_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) pending.push_back(tx_data);
    end

    logic        exp_bits[16];
    int          exp_slots;
    logic        act_bits[16];
    logic [15:0] last_pat;
    int          last_slots = 0;
    int          frame_cnt = 0;
    int          k = 0;
    bit          in_frame = 0;
    int          wait_cnt = 0;
    int          tick_bad = 0;
    int          reset_bad = 0, ready_bad = 0, busy_bad = 0, done_bad = 0, gap_bad = 0, idle_bad = 0;

    task automatic build_frame(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par, input logic s2);
        int  n = int'(nb);
        logic p = 1'b0;
        if (n < 5) n = 5;
        if (n > 8) n = 8;
        exp_slots = 0;
        exp_bits[exp_slots++] = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_bits[exp_slots++] = d[i];
            p ^= d[i];
        end
        if (par == 2'b01) exp_bits[exp_slots++] = p;
        if (par == 2'b10) exp_bits[exp_slots++] = ~p;
        exp_bits[exp_slots++] = 1'b1;
        if (s2) exp_bits[exp_slots++] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            in_frame = 0;
            pending.delete();
            wait_cnt = 0;
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0) reset_bad++;
        end else begin
            if (!in_frame) begin
                if (tx === 1'b0 && pending.size() != 0) begin
                    build_frame(pending.pop_front(), e_bits, e_par, e_s2);
                    in_frame = 1;
                    k        = 0;
                    tick_bad = 0;
                    wait_cnt = 0;
                end else begin
                    if (tx !== 1'b1) idle_bad++;
                    if (pending.size() != 0) begin
                        wait_cnt++;
                        if (wait_cnt > 1) gap_bad++;
                    end
                end
            end
            if (tx_ready !== (pending.size() == 0)) ready_bad++;
            if (tx_busy !== in_frame) busy_bad++;
            if (in_frame && s_tick === 1'b1) begin
                if (tx !== exp_bits[k / OS]) tick_bad++;
                act_bits[k / OS] = tx;
                if (k == exp_slots * OS - 1) begin
                    check("frame_line_ticks", tick_bad, 0);
                    check("frame_done_tick", tx_done_tick, 1);
                    last_pat = '0;
                    for (int s = 0; s < exp_slots; s++) last_pat[s] = act_bits[s];
                    last_slots = exp_slots;
                    frame_cnt++;
                    in_frame = 0;
                    wait_cnt = (pending.size() != 0) ? 1 : 0;
                end else begin
                    if (tx_done_tick !== 1'b0) done_bad++;
                    k++;
                end
            end else if (tx_done_tick !== 1'b0) begin
                done_bad++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int nb, input int par, input bit s2);
        cfg_data_bits = 4'(nb);
        cfg_parity    = 2'(par);
        cfg_stop2     = s2;
    endtask

    task automatic send(input logic [7:0] d);
        int t = 0;
        while (tx_ready !== 1'b1 && t < 20000) begin
            cyc();
            t++;
        end
        if (t >= 20000) check("send_ready_timeout", 0, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        cyc();
        tx_valid = 1'b0;
        tx_data  = $urandom();
    endtask

    task automatic wait_frames(input int target, input string name);
        int t = 0;
        while (frame_cnt < target && t < 20000) begin
            cyc();
            t++;
        end
        check(name, frame_cnt, target);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  nbits;
        logic [1:0]  par;
        logic        stop2;
        int          slots;
        logic [15:0] pat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int fc;
        int bad;
        int t;

        vecs[0] = '{8'hA5, 4'd8,  2'd0, 1'b0, 10, 16'h034A};
        vecs[1] = '{8'h53, 4'd7,  2'd1, 1'b1, 11, 16'h06A6};
        vecs[2] = '{8'h53, 4'd7,  2'd2, 1'b1, 11, 16'h07A6};
        vecs[3] = '{8'h3C, 4'd8,  2'd0, 1'b0, 10, 16'h0278};
        vecs[4] = '{8'hF6, 4'd3,  2'd1, 1'b0,  8, 16'h00EC};
        vecs[5] = '{8'h01, 4'd15, 2'd3, 1'b1, 11, 16'h0602};

        reset_n  = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        set_cfg(8, 0, 0);
        #3 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        tick_mode = 1;
        check("reset_tx", tx, 1);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_tx_busy", tx_busy, 0);
        bad = 0;
        repeat (1000) begin
            cyc();
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0) bad++;
        end
        check("idle_1000_cycles", bad, 0);

        tick_mode = 0;
        fc = frame_cnt;
        send(8'hA5);
        check("latency_tx_still_high", tx, 1);
        check("latency_ready_low", tx_ready, 0);
        cyc();
        check("latency_tx_falls", tx, 0);
        check("latency_busy", tx_busy, 1);
        wait_frames(fc + 1, "latency_frame_end");

        for (int i = 0; i < 6; i++) begin
            set_cfg(vecs[i].nbits, vecs[i].par, vecs[i].stop2);
            fc = frame_cnt;
            send(vecs[i].data);
            wait_frames(fc + 1, $sformatf("vec%0d_frame_end", i));
            check($sformatf("vec%0d_slots", i), last_slots, vecs[i].slots);
            check($sformatf("vec%0d_line", i), last_pat, vecs[i].pat);
        end

        tick_mode = 1;
        set_cfg(5, 0, 0);
        fc = frame_cnt;
        send(8'hFF);
        send(8'h00);
        bad = 0;
        t = 0;
        while (frame_cnt == fc && t < 5000) begin
            cyc();
            t++;
            if (frame_cnt == fc && tx_ready !== 1'b0) bad++;
        end
        check("b2b_ready_low_while_held", bad, 0);
        check("b2b_second_start_no_gap", tx, 0);
        check("b2b_busy", tx_busy, 1);
        check("b2b_ready_after_drain", tx_ready, 1);
        check("b2b_first_line", last_pat, 16'h007E);
        wait_frames(fc + 2, "b2b_second_end");
        check("b2b_second_line", last_pat, 16'h0040);

        tick_mode = 0;
        set_cfg(8, 0, 0);
        fc = frame_cnt;
        send(8'h96);
        send(8'h69);
        repeat (20) cyc();
        set_cfg(5, 2, 1);
        wait_frames(fc + 1, "cfgchg_first_end");
        check("cfgchg_first_slots", last_slots, 10);
        check("cfgchg_first_line", last_pat, 16'h032C);
        wait_frames(fc + 2, "cfgchg_second_end");
        check("cfgchg_second_slots", last_slots, 9);
        check("cfgchg_second_line", last_pat, 16'h01D2);

        set_cfg(8, 0, 0);
        fc = frame_cnt;
        send(8'hA5);
        send(8'hC3);
        t = 0;
        while (!(in_frame && (k / OS) == 4) && t < 5000) begin
            cyc();
            t++;
        end
        check("rst_reached_data_bit3", t < 5000, 1);
        check("rst_hold_full_before", tx_ready, 0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_tx_high", tx, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done_tick", tx_done_tick, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_no_frame_counted", frame_cnt, fc);
        send(8'h3C);
        wait_frames(fc + 1, "rst_new_frame_end");
        check("rst_new_frame_line", last_pat, 16'h0278);
        repeat (300) cyc();
        check("rst_held_word_discarded", frame_cnt, fc + 1);
        check("rst_line_idle", tx, 1);

        fc = frame_cnt;
        for (int i = 0; i < 12; i++) begin
            tick_mode = $urandom_range(0, 2);
            set_cfg($urandom_range(3, 10), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 40)) cyc();
            send(8'($urandom()));
        end
        wait_frames(fc + 12, "random_frames_all_sent");

        check("reset_window_outputs", reset_bad, 0);
        check("tx_ready_vs_model", ready_bad, 0);
        check("tx_busy_vs_model", busy_bad, 0);
        check("spurious_done_tick", done_bad, 0);
        check("idle_gap_before_start", gap_bad, 0);
        check("idle_line_high", idle_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
